inst_cache_fill: RTL and testbench

Miss-fill engine for the instruction cache. On a lookup miss it issues a single line read to the memory port and collects the burst beats into a full cache line. It then issues one write command to the per-way data, tag and valid arrays and signals completion. It drives the array write side (csb/web/addr/din), and its timing accounts for the arrays' registered-command, next-edge-commit write behaviour.

---
 rtl/inst_cache_fill_pkg.sv | 32 +++
 rtl/inst_cache_fill.sv | 116 +++++++++++
 tb/tb_inst_cache_fill.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_cache_fill_pkg.sv
// Shared types and constants for the instruction cache.
// Holds the fill FSM states and the line address layout.
package inst_cache_pkg;

  localparam int OFFSET_W = 5;
  localparam int S_INDEX_DEF = 4;
  localparam int BEAT_W_DEF = 64;
  localparam int BEATS_DEF = 4;
  localparam int LINE_W = BEAT_W_DEF * BEATS_DEF;

  function automatic int tag_w(input int s_index);
    return 32 - OFFSET_W - s_index;
  endfunction

  localparam int TAG_W_DEF = tag_w(S_INDEX_DEF);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RECV,
    WRITE,
    SETTLE,
    DONE
  } fill_state_t;

  typedef struct packed {
    logic [TAG_W_DEF-1:0]   tag;
    logic [S_INDEX_DEF-1:0] index;
    logic [OFFSET_W-1:0]    offset;
  } line_addr_t;

endpackage

// File: rtl/inst_cache_fill.sv
// Instruction cache miss-fill engine: one line read, beat
// collection, then a single write to the data/tag/valid arrays.
module inst_cache_fill
  import inst_cache_pkg::*;
#(
  parameter int S_INDEX = 4,
  parameter int WAYS = 4,
  parameter int BEAT_W = 64,
  parameter int BEATS = 4,
  localparam int WAY_W = $clog2(WAYS),
  localparam int LINE_W = BEAT_W * BEATS,
  localparam int TAG_W = tag_w(S_INDEX)
) (
  input  logic              clk0,
  input  logic              rst0,
  input  logic              miss_req,
  input  logic [31:0]       miss_addr,
  input  logic [WAY_W-1:0]  miss_way,
  output logic              busy,
  output logic              fill_done,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid,
  output logic              arr_csb,
  output logic              arr_web,
  output logic [S_INDEX-1:0] arr_addr,
  output logic [WAYS-1:0]   arr_way_we,
  output logic [LINE_W-1:0] data_din,
  output logic [TAG_W-1:0]  tag_din,
  output logic              valid_din
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  fill_state_t state_q, state_d;
  logic [31:0]       addr_q;
  logic [WAY_W-1:0]  way_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [LINE_W-1:0] buf_q;
  logic              latch;
  logic              accept;
  logic              last;

  assign latch  = (state_q == IDLE) && miss_req;
  assign accept = (state_q == RECV) && bmem_rvalid
                  && (bmem_raddr == addr_q);
  assign last   = accept && (cnt_q == CNT_W'(BEATS - 1));

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == REQ && bmem_ready) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Address, way and line buffer carry no reset.
  always_ff @(posedge clk0) begin
    if (latch) begin
      addr_q <= {miss_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
      way_q  <= miss_way;
    end
    if (accept) begin
      buf_q[cnt_q*BEAT_W +: BEAT_W] <= bmem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss_req) state_d = REQ;
      REQ:     if (bmem_ready) state_d = RECV;
      RECV:    if (last) state_d = WRITE;
      WRITE:   state_d = SETTLE;
      SETTLE:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced idle while reset is held.
  always_comb begin
    busy       = 1'b0;
    fill_done  = 1'b0;
    bmem_read  = 1'b0;
    arr_csb    = 1'b1;
    arr_web    = 1'b1;
    arr_way_we = '0;
    if (!rst0) begin
      busy      = (state_q != IDLE);
      fill_done = (state_q == DONE);
      bmem_read = (state_q == REQ);
      if (state_q == WRITE) begin
        arr_csb    = 1'b0;
        arr_web    = 1'b0;
        arr_way_we = WAYS'(1) << way_q;
      end
    end
  end

  assign bmem_addr = addr_q;
  assign arr_addr  = addr_q[OFFSET_W+S_INDEX-1:OFFSET_W];
  assign tag_din   = addr_q[31:OFFSET_W+S_INDEX];
  assign data_din  = buf_q;
  assign valid_din = 1'b1;

endmodule

// File: tb/tb_inst_cache_fill.sv
// Directed bench for inst_cache_fill with a registered-command
// array model that commits writes on the following edge.
module tb_inst_cache_fill;
  import inst_cache_pkg::*;

  localparam int SETS = 16;

  logic         clk0;
  logic         rst0;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic [1:0]   miss_way;
  logic         busy;
  logic         fill_done;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;
  logic         arr_csb;
  logic         arr_web;
  logic [3:0]   arr_addr;
  logic [3:0]   arr_way_we;
  logic [255:0] data_din;
  logic [22:0]  tag_din;
  logic         valid_din;

  int n_checks = 0;
  int n_fail = 0;
  int req_cnt = 0;
  int wr_cnt = 0;

  inst_cache_fill dut (
    .clk0(clk0), .rst0(rst0),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .miss_way(miss_way), .busy(busy),
    .fill_done(fill_done), .bmem_addr(bmem_addr),
    .bmem_read(bmem_read), .bmem_ready(bmem_ready),
    .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata),
    .bmem_rvalid(bmem_rvalid), .arr_csb(arr_csb),
    .arr_web(arr_web), .arr_addr(arr_addr),
    .arr_way_we(arr_way_we), .data_din(data_din),
    .tag_din(tag_din), .valid_din(valid_din)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  logic [255:0] m_data [4][SETS];
  logic [22:0]  m_tag  [4][SETS];
  logic         m_valid[4][SETS];
  logic         c_we;
  logic [3:0]   c_addr;
  logic [3:0]   c_way;
  logic [255:0] c_data;
  logic [22:0]  c_tag;
  logic         c_valid;

  always @(posedge clk0) begin
    if (rst0) begin
      c_we <= 1'b0;
      for (int w = 0; w < 4; w++)
        for (int s = 0; s < SETS; s++)
          m_valid[w][s] <= 1'b0;
    end else begin
      if (c_we) begin
        for (int w = 0; w < 4; w++) begin
          if (c_way[w]) begin
            m_data[w][c_addr]  <= c_data;
            m_tag[w][c_addr]   <= c_tag;
            m_valid[w][c_addr] <= c_valid;
          end
        end
      end
      c_we    <= !arr_csb && !arr_web;
      c_addr  <= arr_addr;
      c_way   <= arr_way_we;
      c_data  <= data_din;
      c_tag   <= tag_din;
      c_valid <= valid_din;
    end
  end

  always @(posedge clk0) begin
    if (!rst0 && bmem_read && bmem_ready) req_cnt++;
    if (!arr_csb) wr_cnt++;
  end

  function automatic bit hit(input logic [31:0] a,
                             input int w,
                             input logic [255:0] d);
    line_addr_t la;
    la = a;
    return m_valid[w][la.index] === 1'b1
      && m_tag[w][la.index] === la.tag
      && m_data[w][la.index] === d;
  endfunction

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic start_fill(input logic [31:0] a,
                            input logic [1:0] w);
    miss_req = 1'b1;
    miss_addr = a;
    miss_way = w;
    tick();
    miss_req = 1'b0;
  endtask

  task automatic grant();
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
  endtask

  task automatic beat(input logic [31:0] ra,
                      input logic [63:0] d);
    bmem_rvalid = 1'b1;
    bmem_raddr = ra;
    bmem_rdata = d;
    tick();
    bmem_rvalid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (fill_done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b1;
    miss_req = 1'b0;
    miss_addr = '0;
    miss_way = '0;
    bmem_ready = 1'b0;
    bmem_raddr = '0;
    bmem_rdata = '0;
    bmem_rvalid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    n_checks++;
    if (fill_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done got %b want 0", fill_done);
    end
    n_checks++;
    if (bmem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_read got %b want 0", bmem_read);
    end
    n_checks++;
    if ({arr_csb, arr_web} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_csb_web got %b%b want 11",
               arr_csb, arr_web);
    end
    n_checks++;
    if (arr_way_we !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_way_we got %b want 0000", arr_way_we);
    end
    rst0 = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || bmem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset busy %b read %b want 0 0",
               busy, bmem_read);
    end
  endtask

  logic [63:0]  bt[4];
  logic [255:0] line_basic;

  task automatic test_basic();
    int lat;
    bt[0] = 64'h1111_1111_1111_1111;
    bt[1] = 64'h2222_2222_2222_2222;
    bt[2] = 64'h3333_3333_3333_3333;
    bt[3] = 64'h4444_4444_4444_4444;
    line_basic = {bt[3], bt[2], bt[1], bt[0]};
    start_fill(32'h0000_1234, 2'd2);
    n_checks++;
    if (bmem_read !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_req read %b busy %b want 1 1",
               bmem_read, busy);
    end
    n_checks++;
    if (bmem_addr !== 32'h0000_1220) begin
      n_fail++;
      $display("FAIL basic_addr got %h want 00001220", bmem_addr);
    end
    grant();
    n_checks++;
    if (bmem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_recv_read got %b want 0", bmem_read);
    end
    for (int k = 0; k < 4; k++) beat(32'h0000_1220, bt[k]);
    n_checks++;
    if ({arr_csb, arr_web} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_wr_en got %b%b want 00",
               arr_csb, arr_web);
    end
    n_checks++;
    if (arr_addr !== 4'd1 || arr_way_we !== 4'b0100) begin
      n_fail++;
      $display("FAIL basic_wr_sel addr %h way %b want 1 0100",
               arr_addr, arr_way_we);
    end
    n_checks++;
    if (tag_din !== 23'h000009 || valid_din !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_tag got %h/%b want 000009/1",
               tag_din, valid_din);
    end
    n_checks++;
    if (data_din !== line_basic) begin
      n_fail++;
      $display("FAIL basic_data got %h want %h",
               data_din, line_basic);
    end
    wait_done(lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL basic_latency got %0d want 3", lat);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || fill_done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle busy %b done %b want 0 0",
               busy, fill_done);
    end
  endtask

  task automatic test_read_after_fill();
    n_checks++;
    if (hit(32'h0000_1220, 2, line_basic) !== 1'b1) begin
      n_fail++;
      $display("FAIL raf_hit way2 got miss want hit v=%b tag=%h",
               m_valid[2][1], m_tag[2][1]);
    end
    n_checks++;
    if (m_valid[1][1] !== 1'b0) begin
      n_fail++;
      $display("FAIL raf_other_way v got %b want 0", m_valid[1][1]);
    end
  endtask

  task automatic test_backpressure();
    int r0;
    int lat;
    int bad;
    r0 = req_cnt;
    bad = 0;
    start_fill(32'h0000_4567, 2'd1);
    for (int i = 0; i < 5; i++) begin
      if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_4560)
        bad++;
      tick();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bp_hold unstable cycles got %0d want 0", bad);
    end
    grant();
    n_checks++;
    if (req_cnt - r0 !== 1) begin
      n_fail++;
      $display("FAIL bp_req_count got %0d want 1", req_cnt - r0);
    end
    n_checks++;
    if (bmem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_read_drop got %b want 0", bmem_read);
    end
    for (int k = 0; k < 4; k++)
      beat(32'h0000_4560, 64'hB000_0000_0000_0000 | 64'(k));
    n_checks++;
    if (arr_csb !== 1'b0 || arr_way_we !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_write csb %b way %b want 0 0010",
               arr_csb, arr_way_we);
    end
    wait_done(lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL bp_latency got %0d want 3", lat);
    end
    tick();
  endtask

  task automatic test_gapped_stray();
    logic [63:0]  g[4];
    logic [255:0] exp_line;
    int lat;
    g[0] = 64'hA0A0_0000_0000_0001;
    g[1] = 64'hA1A1_0000_0000_0002;
    g[2] = 64'hA2A2_0000_0000_0003;
    g[3] = 64'hA3A3_0000_0000_0004;
    exp_line = {g[3], g[2], g[1], g[0]};
    start_fill(32'h0000_0AC0, 2'd3);
    grant();
    for (int k = 0; k < 4; k++) begin
      if (k == 2) beat(32'h0000_2000, 64'hDEAD_BEEF_DEAD_BEEF);
      if (k == 3) begin
        n_checks++;
        if (arr_csb !== 1'b1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL gap_early_write csb %b busy %b want 1 1",
                   arr_csb, busy);
        end
      end
      repeat (2) tick();
      beat(32'h0000_0AC0, g[k]);
    end
    n_checks++;
    if (arr_csb !== 1'b0 || arr_addr !== 4'd6
        || tag_din !== 23'h5) begin
      n_fail++;
      $display("FAIL gap_write csb %b addr %h tag %h want 0 6 5",
               arr_csb, arr_addr, tag_din);
    end
    n_checks++;
    if (data_din !== exp_line) begin
      n_fail++;
      $display("FAIL gap_data got %h want %h", data_din, exp_line);
    end
    wait_done(lat);
    tick();
    n_checks++;
    if (hit(32'h0000_0AC0, 3, exp_line) !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_lookup got miss want hit lat=%0d", lat);
    end
  endtask

  task automatic test_reset_mid_recv();
    logic [255:0] exp_line;
    int w0;
    int lat;
    w0 = wr_cnt;
    start_fill(32'h0000_3000, 2'd0);
    grant();
    beat(32'h0000_3000, 64'hC0);
    beat(32'h0000_3000, 64'hC1);
    rst0 = 1'b1;
    bmem_rvalid = 1'b1;
    bmem_raddr = 32'h0000_3000;
    bmem_rdata = 64'hC2;
    tick();
    rst0 = 1'b0;
    bmem_rvalid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || bmem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_idle busy %b read %b want 0 0",
               busy, bmem_read);
    end
    beat(32'h0000_3000, 64'hC3);
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b0 || wr_cnt !== w0) begin
      n_fail++;
      $display("FAIL rst_no_write busy %b writes %0d want 0 %0d",
               busy, wr_cnt, w0);
    end
    exp_line = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
    start_fill(32'h0000_3000, 2'd0);
    grant();
    for (int k = 0; k < 4; k++)
      beat(32'h0000_3000, 64'hD0 + 64'(k));
    n_checks++;
    if (arr_csb !== 1'b0 || data_din !== exp_line
        || arr_way_we !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_refill csb %b way %b data %h want 0 0001 %h",
               arr_csb, arr_way_we, data_din, exp_line);
    end
    wait_done(lat);
    tick();
    n_checks++;
    if (hit(32'h0000_3000, 0, exp_line) !== 1'b1 || lat !== 3) begin
      n_fail++;
      $display("FAIL rst_refill_lookup lat %0d want hit and 3", lat);
    end
  endtask

  task automatic test_req_in_done();
    int lat;
    start_fill(32'h0000_5000, 2'd1);
    grant();
    for (int k = 0; k < 4; k++) beat(32'h0000_5000, 64'hE0);
    wait_done(lat);
    n_checks++;
    if (fill_done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_reach got %b want 1", fill_done);
    end
    miss_req = 1'b1;
    miss_addr = 32'h0000_6000;
    miss_way = 2'd2;
    tick();
    n_checks++;
    if (busy !== 1'b0 || bmem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL done_not_latched busy %b read %b want 0 0",
               busy, bmem_read);
    end
    tick();
    miss_req = 1'b0;
    n_checks++;
    if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_6000) begin
      n_fail++;
      $display("FAIL idle_latch read %b addr %h want 1 00006000",
               bmem_read, bmem_addr);
    end
    grant();
    for (int k = 0; k < 4; k++) beat(32'h0000_6000, 64'hF0);
    n_checks++;
    if (arr_csb !== 1'b0 || arr_way_we !== 4'b0100) begin
      n_fail++;
      $display("FAIL relatch_write csb %b way %b want 0 0100",
               arr_csb, arr_way_we);
    end
    wait_done(lat);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_read_after_fill();
    test_backpressure();
    test_gapped_stray();
    test_reset_mid_recv();
    test_req_in_done();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
